spart_rx_fifo: RTL and testbench
================================

SPART_RX_FIFO -- requirements
Module: spart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning the number of data bits per frame (legal range 5..8).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the receive FIFO entry count (power of two, 2..16).
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, meaning enable ticks per bit period (even, 8..32).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: one-cycle tick at OVERSAMPLE x baud.
REQ-007 The block SHALL have port RX, input, 1 bit: asynchronous serial line, idle high.
REQ-008 The block SHALL have port IOCS, input, 1 bit: chip select.
REQ-009 The block SHALL have port iorw, input, 1 bit: 0 = read, 1 = write.
REQ-010 The block SHALL have port addr, input, 2 bits: register select.
REQ-011 The block SHALL have port rx_data, inout, 8 bits: shared data bus.
REQ-012 The block SHALL have port RDA, output, 1 bit: receive data available, high when the FIFO is not empty.

Function
REQ-013 RX SHALL pass through a 2-flop synchronizer; all frame logic SHALL use the synchronized value.
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP. Counters (tick counter, bit counter) SHALL advance only on enable.
REQ-015 IDLE: a low synchronized RX on an enable tick -> START, with tick counter cleared.
REQ-016 START: at tick OVERSAMPLE/2-1, RX high -> IDLE (false start, nothing recorded); RX low -> DATA, with counters cleared.
REQ-017 DATA: every OVERSAMPLE ticks, one bit SHALL be sampled, LSB first, into a DATA_BITS shift register; after DATA_BITS bits -> PARITY if enabled, else STOP.
REQ-018 STOP: at the sample point, RX high SHALL push the data, zero-extended to 8 bits, into the FIFO; RX low SHALL set sticky FE and discard the frame. In either case -> IDLE.
REQ-019 A push into a full FIFO SHALL be dropped and SHALL set sticky OE; existing contents are unchanged.
REQ-020 Data read (IOCS=1, iorw=0, addr=00) SHALL drive the FIFO head onto rx_data and pop one entry per asserted clock cycle; reading an empty FIFO SHALL return 8'h00 with no pop.
REQ-021 Status read (IOCS=1, iorw=0, addr=01) SHALL drive {count[4:0], PE, FE, OE}, bit 0 = OE, and SHALL clear PE/FE/OE on that cycle; an error raised in the same cycle SHALL win and remain set.
REQ-022 A simultaneous push and pop SHALL both take effect; when the FIFO is full, the push SHALL succeed with no OE.
REQ-023 rx_data SHALL be high-Z unless IOCS=1, iorw=0 and addr is 00 or 01; writes and addr 10/11 SHALL be ignored.
REQ-024 The FIFO SHALL be a circular buffer with read and write pointers wrapping modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-025 Latency: a valid frame SHALL be visible (RDA=1) on the clock after the stop-bit sample tick.

Reset
REQ-026 On rst: FSM SHALL go to IDLE; counters, shift register, pointers and count SHALL be 0; PE, FE and OE SHALL be 0; RDA SHALL be 0; rx_data SHALL be high-Z; synchronizer flops SHALL be 1.
REQ-027 Reset mid-frame SHALL abandon the frame; reception SHALL resume at the next falling edge after reset is released.

Configuration
REQ-028 With SPART_RX_PARITY_EN defined, the PARITY state SHALL sample one even-parity bit; a mismatch SHALL set sticky PE and discard the frame at STOP.
REQ-029 Without SPART_RX_PARITY_EN, the PARITY state SHALL be unreachable, frames SHALL have no parity bit, and PE SHALL read 0.

Verification
REQ-030 Defaults, no parity; send 0xA5 with a valid stop -> RDA=1; data read returns 0xA5; RDA=0 the next cycle.
REQ-031 RX low pulse of 4 ticks -> no frame; FSM back in IDLE; RDA stays 0; status reads 0x00.
REQ-032 Send 5 frames 0x01..0x05 without reading (FIFO_DEPTH=4) -> status reads 0x21 (count 4, OE); reads return 0x01..0x04; next status reads 0x00.
REQ-033 Send 0x3C with the stop bit low -> FE set, status reads 0x02, RDA stays 0.
REQ-034 Parity enabled; send 0x07 with parity bit 0 -> PE set, status reads 0x04; send 0x07 with parity bit 1 -> data read returns 0x07.
REQ-035 DATA_BITS=7; send 0x7F -> data read returns 0x7F; assert rst mid-frame -> RDA=0, count=0, next frame received correctly.

Source files
------------

// File: rtl/spart_rx_fifo.sv
// spart_rx_fifo: SPART receive path. A 2-flop synchronizer feeds an
// oversampling frame receiver (start, DATA_BITS data LSB first, optional
// even parity, stop). Good frames are pushed into a circular FIFO that is
// read over a shared tri-state bus.
//
// Optional feature macro: SPART_RX_PARITY_EN (adds one even-parity bit per
// frame; a parity mismatch sets sticky PE and the frame is discarded).
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   asynchronous active-high reset
//   enable   in   one-cycle tick at OVERSAMPLE x baud
//   RX       in   asynchronous serial line, idle high
//   IOCS     in   chip select
//   iorw     in   0 = read, 1 = write (writes are ignored)
//   addr     in   00 = data (pop), 01 = status {count[4:0], PE, FE, OE}
//   rx_data  io   shared data bus, high-Z unless a read of addr 00/01
//   RDA      out  FIFO not empty
//
// state  | meaning
// IDLE   | line idle, waiting for a low sample
// START  | checking the start bit at its midpoint
// DATA   | sampling DATA_BITS data bits, one per bit period
// PARITY | sampling the parity bit (parity builds only)
// STOP   | sampling the stop bit, push or flag framing error

module spart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       RX,
    input  logic       IOCS,
    input  logic       iorw,
    input  logic [1:0] addr,
    inout  wire  [7:0] rx_data,
    output logic       RDA
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t               state_q;
    logic                 rx_meta_q, rx_sync_q;
    logic [TW-1:0]        tick_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;

    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 pe_q, fe_q, oe_q;

    logic stop_smp, push_req, fe_set, pe_set, par_ok;
    logic rd_sel, data_rd, stat_rd, pop, full, push, oe_set;
    logic [7:0] rd_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Tick and bit counters count down and act on reaching zero.
    assign stop_smp = (state_q == S_STOP) && enable && (tick_q == '0);

`ifdef SPART_RX_PARITY_EN
    logic par_err_q;
    assign pe_set = (state_q == S_PARITY) && enable && (tick_q == '0)
                    && (rx_sync_q != ^shift_q);
    assign par_ok = !par_err_q;
`else
    assign pe_set = 1'b0;
    assign par_ok = 1'b1;
`endif

    assign push_req = stop_smp && rx_sync_q && par_ok;
    assign fe_set   = stop_smp && !rx_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
`ifdef SPART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_sync_q) begin
                        state_q <= S_START;
                        tick_q  <= TICK_HALF;
                    end
                end
                S_START: begin
                    if (tick_q == '0) begin
                        if (rx_sync_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_DATA;
                            tick_q  <= TICK_FULL;
                            bit_q   <= BIT_LAST;
                        end
                    end else begin
                        tick_q <= tick_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_q == '0) begin
                        shift_q <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
                        tick_q  <= TICK_FULL;
                        if (bit_q == '0) begin
`ifdef SPART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_q <= bit_q - 1'b1;
                        end
                    end else begin
                        tick_q <= tick_q - 1'b1;
                    end
                end
`ifdef SPART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick_q == '0) begin
                        par_err_q <= (rx_sync_q != ^shift_q);
                        state_q   <= S_STOP;
                        tick_q    <= TICK_FULL;
                    end else begin
                        tick_q <= tick_q - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (tick_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        tick_q <= tick_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_sel  = IOCS && !iorw;
    assign data_rd = rd_sel && (addr == 2'b00);
    assign stat_rd = rd_sel && (addr == 2'b01);
    assign pop     = data_rd && (count_q != '0);
    assign full    = (count_q == DEPTH_C);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push    = push_req && (!full || pop);
    assign oe_set  = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= 8'(shift_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A status read clears the flags, but an error raised that cycle wins.
            pe_q <= (pe_q && !stat_rd) || pe_set;
            fe_q <= (fe_q && !stat_rd) || fe_set;
            oe_q <= (oe_q && !stat_rd) || oe_set;
        end
    end

    always_comb begin
        rd_val = 8'h00;
        if (stat_rd) begin
            rd_val = {5'(count_q), pe_q, fe_q, oe_q};
        end else if (count_q != '0) begin
            rd_val = mem_q[rd_ptr_q];
        end
    end

    assign rx_data = (data_rd || stat_rd) ? rd_val : 8'hzz;
    assign RDA     = (count_q != '0);

endmodule

// File: tb/tb_spart_rx_fifo.sv
`timescale 1ns/1ps
module tb_spart_rx_fifo;
    localparam int DEPTH_A = 4;
    localparam int OS_A    = 16;
    localparam int DB_A    = 8;
    localparam int DEPTH_B = 2;
    localparam int OS_B    = 8;
    localparam int DB_B    = 7;
`ifdef SPART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic enable = 1'b0;
    logic rst_a, rx_a, cs_a, rw_a, rda_a;
    logic rst_b, rx_b, cs_b, rw_b, rda_b;
    logic [1:0] addr_a, addr_b;
    wire  [7:0] data_a, data_b;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q_a[$];
    bit pe_m = 1'b0, fe_m = 1'b0, oe_m = 1'b0;

    spart_rx_fifo #(.DATA_BITS(DB_A), .FIFO_DEPTH(DEPTH_A), .OVERSAMPLE(OS_A)) u_dut_a (
        .clk(clk), .rst(rst_a), .enable(enable), .RX(rx_a), .IOCS(cs_a),
        .iorw(rw_a), .addr(addr_a), .rx_data(data_a), .RDA(rda_a)
    );

    spart_rx_fifo #(.DATA_BITS(DB_B), .FIFO_DEPTH(DEPTH_B), .OVERSAMPLE(OS_B)) u_dut_b (
        .clk(clk), .rst(rst_b), .enable(enable), .RX(rx_b), .IOCS(cs_b),
        .iorw(rw_b), .addr(addr_b), .rx_data(data_b), .RDA(rda_b)
    );

    always #5 clk = ~clk;

    // enable ticks on every other rising edge
    initial forever begin
        @(negedge clk);
        enable = ~enable;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (enable !== 1'b1);
        end
        #1;
    endtask

    task automatic set_rx(input bit which, input logic v);
        if (which) rx_b = v; else rx_a = v;
    endtask

    task automatic bus_cycle(input bit which, input bit cs, input bit rw,
                             input logic [1:0] adr, output logic [7:0] d);
        if (which) begin cs_b = cs; rw_b = rw; addr_b = adr; end
        else       begin cs_a = cs; rw_a = rw; addr_a = adr; end
        @(negedge clk);
        d = which ? data_b : data_a;
        @(posedge clk);
        #1;
        cs_a = 1'b0; rw_a = 1'b0; addr_a = 2'b00;
        cs_b = 1'b0; rw_b = 1'b0; addr_b = 2'b00;
    endtask

    task automatic rd(input bit which, input logic [1:0] adr, output logic [7:0] d);
        bus_cycle(which, 1'b1, 1'b0, adr, d);
    endtask

    // Reference model of instance A: FIFO as a queue plus sticky flags.
    function automatic logic [7:0] m_data();
        if (q_a.size() == 0) return 8'h00;
        return q_a.pop_front();
    endfunction

    function automatic logic [7:0] m_status();
        logic [7:0] s;
        s = {5'(q_a.size()), pe_m, fe_m, oe_m};
        pe_m = 1'b0; fe_m = 1'b0; oe_m = 1'b0;
        return s;
    endfunction

    function automatic void m_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
        if (!par_ok) pe_m = 1'b1;
        if (!stop_ok) fe_m = 1'b1;
        else if (par_ok) begin
            if (q_a.size() >= DEPTH_A) oe_m = 1'b1;
            else q_a.push_back(d);
        end
    endfunction

    // mode 0: plain frame; mode 1: check RDA rises on the clock after the
    // stop sample; mode 2: data read coinciding with the stop sample (A only).
    task automatic send(input bit which, input logic [7:0] d, input bit stop_ok,
                        input bit par_ok, input int mode, output logic [7:0] popped);
        int os;
        int db;
        logic [7:0] mask;
        logic par;
        os   = which ? OS_B : OS_A;
        db   = which ? DB_B : DB_A;
        mask = which ? 8'h7F : 8'hFF;
        par  = (^(d & mask)) ^ !par_ok;
        popped = 8'h00;
        set_rx(which, 1'b0);
        wait_tick(os);
        for (int i = 0; i < db; i++) begin
            set_rx(which, d[i]);
            wait_tick(os);
        end
        if (PAR_EN) begin
            set_rx(which, par);
            wait_tick(os);
        end
        if (!stop_ok) begin
            set_rx(which, 1'b0);
            wait_tick(os / 2 + 2);
            set_rx(which, 1'b1);
            wait_tick(os - os / 2 - 2);
        end else begin
            set_rx(which, 1'b1);
            wait_tick(os / 2 + 1);
            if (mode == 1) begin
                check("rda_before_stop_sample", {7'b0, rda_a}, 8'h00);
                @(posedge clk);
                @(posedge clk);
                #1;
                check("rda_after_stop_sample", {7'b0, rda_a}, 8'h01);
            end else if (mode == 2) begin
                @(posedge clk);
                #1;
                rd(1'b0, 2'b00, popped);
            end else begin
                wait_tick(1);
            end
            wait_tick(os - os / 2 - 2);
        end
        wait_tick(os);
    endtask

    initial begin
        logic [7:0] d, e, v;
        bit stop_ok, par_ok;
        int act;

        rst_a = 1'b1; rst_b = 1'b1;
        rx_a = 1'b1; rx_b = 1'b1;
        cs_a = 1'b0; cs_b = 1'b0; rw_a = 1'b0; rw_b = 1'b0;
        addr_a = 2'b00; addr_b = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        wait_tick(2);

        check("reset_rda", {7'b0, rda_a}, 8'h00);
        rd(1'b0, 2'b01, d);
        check("reset_status", d, m_status());
        rd(1'b0, 2'b00, d);
        check("empty_read", d, m_data());

        send(1'b0, 8'hA5, 1'b1, 1'b1, 1, d);
        m_frame(8'hA5, 1'b1, 1'b1);
        rd(1'b0, 2'b00, d);
        check("read_a5", d, m_data());
        check("rda_after_pop", {7'b0, rda_a}, 8'h00);

        set_rx(1'b0, 1'b0);
        wait_tick(4);
        set_rx(1'b0, 1'b1);
        wait_tick(2 * OS_A);
        check("false_start_rda", {7'b0, rda_a}, 8'h00);
        rd(1'b0, 2'b01, d);
        check("false_start_status", d, m_status());

        for (int i = 1; i <= 5; i++) begin
            send(1'b0, 8'(i), 1'b1, 1'b1, 0, d);
            m_frame(8'(i), 1'b1, 1'b1);
        end
        rd(1'b0, 2'b01, d);
        check("overrun_status", d, m_status());
        for (int i = 0; i < 4; i++) begin
            rd(1'b0, 2'b00, d);
            check("overrun_read", d, m_data());
        end
        rd(1'b0, 2'b01, d);
        check("overrun_status_cleared", d, m_status());

        send(1'b0, 8'h3C, 1'b0, 1'b1, 0, d);
        m_frame(8'h3C, 1'b0, 1'b1);
        check("framing_rda", {7'b0, rda_a}, 8'h00);
        rd(1'b0, 2'b01, d);
        check("framing_status", d, m_status());

        // Writes, addr 10/11 and deselected reads must neither pop nor clear.
        send(1'b0, 8'h5A, 1'b1, 1'b1, 0, d);
        m_frame(8'h5A, 1'b1, 1'b1);
        bus_cycle(1'b0, 1'b1, 1'b1, 2'b00, d);
        bus_cycle(1'b0, 1'b1, 1'b0, 2'b10, d);
        bus_cycle(1'b0, 1'b1, 1'b0, 2'b11, d);
        bus_cycle(1'b0, 1'b0, 1'b0, 2'b00, d);
        check("ignored_rda", {7'b0, rda_a}, 8'h01);
        rd(1'b0, 2'b01, d);
        check("ignored_status", d, m_status());
        rd(1'b0, 2'b00, d);
        check("ignored_read", d, m_data());

        for (int i = 0; i < 4; i++) begin
            send(1'b0, 8'(8'h11 + i), 1'b1, 1'b1, 0, d);
            m_frame(8'(8'h11 + i), 1'b1, 1'b1);
        end
        send(1'b0, 8'h15, 1'b1, 1'b1, 2, d);
        e = m_data();
        m_frame(8'h15, 1'b1, 1'b1);
        check("pop_at_push", d, e);
        rd(1'b0, 2'b01, d);
        check("pop_push_full_status", d, m_status());
        for (int i = 0; i < 4; i++) begin
            rd(1'b0, 2'b00, d);
            check("pop_push_read", d, m_data());
        end

`ifdef SPART_RX_PARITY_EN
        send(1'b0, 8'h07, 1'b1, 1'b0, 0, d);
        m_frame(8'h07, 1'b1, 1'b0);
        rd(1'b0, 2'b01, d);
        check("parity_err_status", d, m_status());
        send(1'b0, 8'h07, 1'b1, 1'b1, 0, d);
        m_frame(8'h07, 1'b1, 1'b1);
        rd(1'b0, 2'b00, d);
        check("parity_ok_read", d, m_data());
`endif

        for (int n = 0; n < 14; n++) begin
            v       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 5) != 0);
            par_ok  = PAR_EN ? ($urandom_range(0, 4) != 0) : 1'b1;
            send(1'b0, v, stop_ok, par_ok, 0, d);
            m_frame(v, stop_ok, par_ok);
            check("rand_rda", {7'b0, rda_a}, {7'b0, (q_a.size() != 0)});
            act = $urandom_range(0, 3);
            if (act == 1 || act == 3) begin
                rd(1'b0, 2'b00, d);
                check("rand_read", d, m_data());
            end
            if (act == 2 || act == 3) begin
                rd(1'b0, 2'b01, d);
                check("rand_status", d, m_status());
            end
        end
        rd(1'b0, 2'b01, d);
        check("drain_status", d, m_status());
        for (int i = 0; i <= DEPTH_A; i++) begin
            rd(1'b0, 2'b00, d);
            check("drain_read", d, m_data());
        end

        // Instance B: 7 data bits, reset in the middle of a frame.
        send(1'b1, 8'h7F, 1'b1, 1'b1, 0, d);
        rd(1'b1, 2'b00, d);
        check("b_read_7f", d, 8'h7F);
        send(1'b1, 8'h55, 1'b1, 1'b1, 0, d);
        check("b_rda_before_reset", {7'b0, rda_b}, 8'h01);
        set_rx(1'b1, 1'b0);
        wait_tick(OS_B + 3);
        rst_b = 1'b1;
        set_rx(1'b1, 1'b1);
        wait_tick(2);
        rst_b = 1'b0;
        wait_tick(2 * OS_B);
        check("b_rda_after_reset", {7'b0, rda_b}, 8'h00);
        rd(1'b1, 2'b01, d);
        check("b_status_after_reset", d, 8'h00);
        send(1'b1, 8'h2A, 1'b1, 1'b1, 0, d);
        rd(1'b1, 2'b00, d);
        check("b_read_after_reset", d, 8'h2A);
        rd(1'b1, 2'b01, d);
        check("b_status_final", d, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
